md_unit: RTL and testbench

Multiply/divide unit for the P7 pipeline's EX stage. It consumes `start`, `MDCCtrl`, `MDM_WE` and `MDM_RE` from the control signal generator, plus both EX-stage operands. It holds the architectural HI/LO registers and runs mult/multu/div/divu/madd as fixed-latency multicycle operations. Its `busy` output feeds the hazard unit, which stalls any later MD-class instruction in D until `busy` and `start` are both low.

---
 rtl/md_unit.sv | 137 +++++++++++++
 tb/tb_md_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO and runs mult/multu/div/divu/madd
// as fixed-latency operations whose result commits when the countdown expires.
module md_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDCCtrl,
  input  logic [1:0]  MDM_WE,
  input  logic [1:0]  MDM_RE,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] MDM_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // state | meaning
  // IDLE  | cnt == 0, accepts start and mthi/mtlo
  // RUN   | cnt != 0, counting down to the HI/LO commit

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;

  localparam int MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e        state;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_r, lo_r;
  logic [31:0]   pend_hi, pend_lo;
  logic [31:0]   op_b;
  logic [2:0]    op_sel;

  logic          valid_op, is_div_in, signed_div, accept, wr_en, commit_skip;
  logic [63:0]   prod_s, prod_u, result;
  logic [31:0]   mag_a, mag_b, div_den, q_mag, r_mag, quot, rem;

  assign valid_op   = (MDCCtrl <= OP_MADD);
  assign is_div_in  = (MDCCtrl == OP_DIV) || (MDCCtrl == OP_DIVU);
  assign signed_div = (MDCCtrl == OP_DIV);
  assign accept     = start && !req && (state == ST_IDLE) && valid_op;
  // any non-cancelled start drops a same-cycle mthi/mtlo
  assign wr_en      = (state == ST_IDLE) && !req && !start;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'b0, A} * {32'b0, B};

  // sign-magnitude divide keeps 0x80000000 / -1 well defined
  assign mag_a   = (signed_div && A[31]) ? (~A + 32'd1) : A;
  assign mag_b   = (signed_div && B[31]) ? (~B + 32'd1) : B;
  assign div_den = (B == 32'd0) ? 32'd1 : mag_b;
  assign q_mag   = mag_a / div_den;
  assign r_mag   = mag_a % div_den;
  assign quot    = (signed_div && (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
  assign rem     = (signed_div && A[31]) ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    result = 64'd0;
    case (MDCCtrl)
      OP_MULT, OP_MADD: result = prod_s;
      OP_MULTU:         result = prod_u;
      OP_DIV, OP_DIVU:  result = {rem, quot};
      default:          result = 64'd0;
    endcase
  end

  assign commit_skip = ((op_sel == OP_DIV) || (op_sel == OP_DIVU)) && (op_b == 32'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      op_b    <= 32'd0;
      op_sel  <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_b    <= B;
            op_sel  <= MDCCtrl;
            pend_hi <= result[63:32];
            pend_lo <= result[31:0];
            cnt     <= is_div_in ? DIV_LOAD : MUL_LOAD;
            state   <= ST_RUN;
          end else if (wr_en) begin
            if (MDM_WE == 2'b01) hi_r <= A;
            if (MDM_WE == 2'b10) lo_r <= A;
          end
        end
        ST_RUN: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= ST_IDLE;
            if (op_sel == OP_MADD)
              {hi_r, lo_r} <= {hi_r, lo_r} + {pend_hi, pend_lo};
            else if (!commit_skip) begin
              hi_r <= pend_hi;
              lo_r <= pend_lo;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign HI   = hi_r;
  assign LO   = lo_r;

  always_comb begin
    MDM_out = 32'd0;
    case (MDM_RE)
      2'b01:   MDM_out = hi_r;
      2'b10:   MDM_out = lo_r;
      default: MDM_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed scoreboard bench for md_unit: expected HI/LO pushed at launch, popped at commit.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MDCCtrl;
  logic [1:0]  MDM_WE;
  logic [1:0]  MDM_RE;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] MDM_out;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors = 0;
  int errs    = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];

  md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDCCtrl(MDCCtrl),
    .MDM_WE(MDM_WE), .MDM_RE(MDM_RE), .A(A), .B(B), .req(req),
    .busy(busy), .MDM_out(MDM_out), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.tag = tag;
    e.hi  = hi;
    e.lo  = lo;
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] we);
    start   = 1'b1;
    MDCCtrl = op;
    A       = a;
    B       = b;
    MDM_WE  = we;
    tick();
    start  = 1'b0;
    MDM_WE = 2'b00;
  endtask

  task automatic write_reg(input logic [1:0] we, input logic [31:0] d);
    MDM_WE = we;
    A      = d;
    tick();
    MDM_WE = 2'b00;
  endtask

  // counts busy cycles (bounded), optionally holding req for the first few, then scores HI/LO
  task automatic wait_done(input int exp_n, input int req_cycles);
    int   n;
    exp_t e;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      req = (n < req_cycles);
      n++;
      tick();
    end
    req = 1'b0;
    check("busy_len", n, exp_n);
    if (sb.size() == 0) begin
      vectors++;
      errs++;
      $error("FAIL sb_empty observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_hi"}, HI, e.hi);
      check({e.tag, "_lo"}, LO, e.lo);
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    MDCCtrl = 3'b000;
    MDM_WE  = 2'b00;
    MDM_RE  = 2'b01;
    A       = 32'd0;
    B       = 32'd0;
    req     = 1'b0;
    #1 reset = 1'b0;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_mdm", MDM_out, 32'd0);
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();

    push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    start_op(3'b000, 32'hFFFF_FFFE, 32'd3, 2'b00);
    wait_done(5, 0);

    push("multu", 32'h0000_0002, 32'hFFFF_FFFA);
    start_op(3'b001, 32'hFFFF_FFFE, 32'd3, 2'b00);
    wait_done(5, 0);

    push("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    start_op(3'b010, 32'hFFFF_FFF9, 32'd2, 2'b00);
    wait_done(10, 0);

    MDM_RE = 2'b01;
    write_reg(2'b01, 32'h11);
    check("mthi_read", MDM_out, 32'h11);
    MDM_RE = 2'b10;
    write_reg(2'b10, 32'h22);
    check("mtlo_read", MDM_out, 32'h22);
    write_reg(2'b11, 32'h99);
    check("we11_hi", HI, 32'h11);
    check("we11_lo", LO, 32'h22);

    push("divu0", 32'h11, 32'h22);
    start_op(3'b011, 32'd7, 32'd0, 2'b00);
    wait_done(10, 0);

    write_reg(2'b01, 32'h0);
    write_reg(2'b10, 32'hFFFF_FFFF);
    push("madd", 32'h1, 32'h0);
    start_op(3'b100, 32'd1, 32'd1, 2'b00);
    MDM_WE = 2'b10;
    A      = 32'h1234;
    tick();
    MDM_WE = 2'b00;
    wait_done(4, 0);

    MDM_RE = 2'b10;
    write_reg(2'b10, 32'h1234);
    check("mtlo_idle_read", MDM_out, 32'h1234);

    req = 1'b1;
    start_op(3'b000, 32'd5, 32'd5, 2'b00);
    req = 1'b0;
    check("req_start_busy", {31'd0, busy}, 32'd0);
    check("req_start_hi", HI, 32'h1);
    check("req_start_lo", LO, 32'h1234);

    push("div_req", 32'd2, 32'd14);
    start_op(3'b010, 32'd100, 32'd7, 2'b00);
    wait_done(10, 3);

    start_op(3'b101, 32'd3, 32'd4, 2'b00);
    check("badop_busy", {31'd0, busy}, 32'd0);
    check("badop_hi", HI, 32'd2);
    check("badop_lo", LO, 32'd14);

    MDM_RE = 2'b01;
    start_op(3'b000, 32'd3, 32'd3, 2'b00);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", HI, 32'd0);
    check("midrst_lo", LO, 32'd0);
    check("midrst_mdm", MDM_out, 32'd0);
    #2 reset = 1'b1;
    tick();

    push("mult67", 32'd0, 32'd42);
    start_op(3'b000, 32'd6, 32'd7, 2'b00);
    wait_done(5, 0);

    push("mult_we", 32'd0, 32'd4);
    start_op(3'b000, 32'd2, 32'd2, 2'b01);
    check("mult_we_drop", HI, 32'd0);
    wait_done(5, 0);

    push("div_ovf", 32'd0, 32'h8000_0000);
    start_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00);
    wait_done(10, 0);

    push("b2b_multu", 32'hFFFF_FFFE, 32'h0000_0001);
    start_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
    wait_done(5, 0);
    MDM_RE = 2'b01;
    #1;
    check("mfhi_after", MDM_out, 32'hFFFF_FFFE);
    MDM_RE = 2'b00;
    #1;
    check("re00_zero", MDM_out, 32'd0);

    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
